apb_spi_fifo_regs: RTL
======================

Name: apb_spi_fifo_regs

Overview:
Next-generation APB register front end for the SPI master. Replaces the single tx_data/rx_data register pair with parametrised TX and RX FIFOs, a valid/ready stream to the SPI engine, a parametrised slave-select count, FIFO level reporting and a sticky overflow flag. Sits between the APB bus and the SPI engine. Merges APB slave decode and the register file into one block.

Parameters:
DATA_W, 32, SPI word width and APB data width (8..32)
NUM_SS, 4, number of slave-enable bits (1..8)
FIFO_DEPTH, 8, entries per FIFO, power of two (2..128)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write(1)/read(0)
paddr  in  8  APB byte address; bits [1:0] ignored
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd  out  1 each  SPI mode bits
ctrl_scks  out  2  clock speed select
ctrl_slave_en  out  NUM_SS  slave enables
tx_data  out  DATA_W  TX FIFO head
tx_valid  out  1  TX word available
tx_ready  in  1  SPI engine accepts tx_data
rx_data  in  DATA_W  received word
rx_valid  in  1  rx_data valid (one cycle per word)
busy  in  1  SPI engine busy

Behaviour:
- Reset (async, rst=1):
  - all control fields 0; both FIFOs empty; overflow flag 0
  - prdata=0, pslverr=0, pready=0, tx_valid=0, tx_data=0
- APB protocol:
  - zero wait states: pready = psel & penable
  - prdata/pslverr are combinational during the access phase and 0 otherwise
  - side effects (register write, push, pop) commit on the clk edge ending the access phase
- Register map:
  - 0x00 CTRL, RW:
    - [0] cpol, [1] cpha, [2] order, [3] rd, [5:4] scks, [6] enable, [8+NUM_SS-1:8] slave_en
    - [7] fifo_clr: write-1 flushes both FIFOs and clears overflow; always reads 0
    - unused bits read 0
  - 0x04 STATUS:
    - [0] busy, [1] tx_empty, [2] tx_full, [3] rx_empty, [4] rx_full, [5] rx_overflow
    - write: bit5 is write-1-to-clear; other bits ignored; no error
  - 0x08 TXDATA, WO:
    - write pushes pwdata[DATA_W-1:0]
    - if TX full: pslverr=1 and data dropped
    - read: pslverr=1, prdata=0
  - 0x0C RXDATA, RO:
    - read returns the head zero-extended and pops it
    - if RX empty: prdata=0 and pslverr=1
    - write: pslverr=1
  - 0x10 LEVEL, RO: [7:0] tx_count, [15:8] rx_count (0..FIFO_DEPTH); write gives pslverr=1
  - any other address: pslverr=1, prdata=0, no side effect
- TX stream:
  - tx_valid = enable & !tx_empty; tx_data = FIFO head (0 when empty)
  - pop on tx_valid & tx_ready
  - clearing enable holds the queue without flushing it
- RX stream:
  - push on rx_valid, independent of enable
  - if RX full at that edge: word dropped, rx_overflow set (sticky)
- FIFO rules:
  - full/empty are evaluated on pre-edge state
  - APB push onto a full TX FIFO is rejected even if a pop occurs in the same cycle
  - APB pop of an empty RX FIFO errors even if rx_valid pushes in the same cycle; that pushed word is stored
  - simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged
  - pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1
- fifo_clr priority: a flush beats a same-cycle stream pop, rx_valid push and overflow set. Counts read 0 on the next access.
- Reset mid-transfer: everything returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Package apb_spi_pkg:
  - register offset localparams
  - CTRL and STATUS bit-position constants
  - typedef ctrl_t: packed struct of the mode fields
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - ports clk, rst, push, pop, wdata, rdata, full, empty, count, flush
  - instantiated twice, once for TX and once for RX
- The top holds APB decode, CTRL/STATUS logic and stream glue.

Test Plan:
- Reset, then read all registers -> CTRL=0, STATUS=0x0A (tx_empty, rx_empty), LEVEL=0, pslverr=0.
- Write CTRL=0x0000_0F5B -> cpol=1, cpha=1, order=0, rd=1, scks=1, enable=1, slave_en=0xF. Readback=0x0000_0F5B (bit7 reads 0).
- enable=0; write TXDATA 9 times with 0x100..0x108 -> 9th write pslverr=1, LEVEL[7:0]=8. Set enable with tx_ready=1 -> tx_data sequence 0x100..0x107 on consecutive cycles, then tx_valid=0.
- Drive 9 rx_valid words 0xA0..0xA8 -> STATUS[5]=1 and rx_count=8. Reads return 0xA0..0xA7; the next read gives pslverr=1, prdata=0. Write STATUS=0x20 -> overflow cleared.
- With TX full, do an APB TXDATA write in the same cycle as a tx_ready pop -> pslverr=1, count becomes 7. Write CTRL with bit7=1 -> both counts 0 next access.
- Read 0x14, write 0x0C, read 0x08 -> pslverr=1 each, prdata=0, no state change. Assert rst mid-burst -> outputs at reset values within the same cycle.

Source files
------------

// File: rtl/apb_spi_fifo_regs_pkg.sv
// ============================================================================
// Module   : apb_spi_pkg
// Brief    : Register map, bit positions and mode-field type for the APB SPI
//            FIFO register front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_spi_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;
  localparam logic [7:0] ADDR_LEVEL  = 8'h10;

  localparam int CTRL_MODE_W   = 7;
  localparam int CTRL_FIFO_CLR = 7;
  localparam int CTRL_SS_LSB   = 8;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_RX_FULL  = 4;
  localparam int STAT_RX_OVF   = 5;

  // Field order mirrors CTRL[6:0] so a write can be cast straight in.
  typedef struct packed {
    logic       enable;
    logic [1:0] scks;
    logic       rd;
    logic       order;
    logic       cpha;
    logic       cpol;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/apb_spi_fifo_regs_if.sv
// ============================================================================
// Module   : apb_spi_fifo_regs_if
// Brief    : APB3 slave bus bundle (8-bit address, 32-bit data).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface apb_spi_fifo_regs_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

`default_nettype wire

// File: rtl/apb_spi_fifo_regs_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO; full/empty gate push/pop, flush wins over both.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic                       flush,
  input  wire logic [WIDTH-1:0]           wdata,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/apb_spi_fifo_regs.sv
// ============================================================================
// Module   : apb_spi_fifo_regs
// Brief    : APB register front end for the SPI master with TX/RX FIFOs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_spi_fifo_regs
  import apb_spi_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  apb_spi_fifo_regs_if.slave     apb,
  output logic                   ctrl_cpol,
  output logic                   ctrl_cpha,
  output logic                   ctrl_order,
  output logic                   ctrl_rd,
  output logic [1:0]             ctrl_scks,
  output logic [NUM_SS-1:0]      ctrl_slave_en,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  wire logic              tx_ready,
  input  wire logic [DATA_W-1:0] rx_data,
  input  wire logic              rx_valid,
  input  wire logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_t             ctrl;
  logic [NUM_SS-1:0] slave_en;
  logic              rx_overflow;

  logic              access;
  logic [7:0]        reg_addr;
  logic [31:0]       rdata;
  logic              err;
  logic              ctrl_wr;
  logic              flush;
  logic              ovf_clr;
  logic              tx_push;
  logic              rx_pop;
  logic              tx_pop;

  logic [DATA_W-1:0] tx_head;
  logic [DATA_W-1:0] rx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     tx_count;
  logic [CW-1:0]     rx_count;
  logic [31:0]       ctrl_word;
  logic [31:0]       status_word;

  logic              unused_ok;
  assign unused_ok = &{1'b0, apb.paddr[1:0]};

  // Gating with rst keeps the bus outputs at reset values immediately.
  assign access   = apb.psel & apb.penable & ~rst;
  assign reg_addr = {apb.paddr[7:2], 2'b00};

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_MODE_W-1:0]        = ctrl;
    ctrl_word[CTRL_SS_LSB +: NUM_SS]  = slave_en;
    status_word = '0;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_TX_EMPTY] = tx_empty;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_RX_FULL]  = rx_full;
    status_word[STAT_RX_OVF]   = rx_overflow;
  end

  always_comb begin
    rdata   = '0;
    err     = 1'b0;
    ctrl_wr = 1'b0;
    flush   = 1'b0;
    ovf_clr = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    if (access) begin
      case (reg_addr)
        ADDR_CTRL: begin
          if (apb.pwrite) begin
            ctrl_wr = 1'b1;
            flush   = apb.pwdata[CTRL_FIFO_CLR];
          end else begin
            rdata = ctrl_word;
          end
        end
        ADDR_STATUS: begin
          if (apb.pwrite) ovf_clr = apb.pwdata[STAT_RX_OVF];
          else            rdata   = status_word;
        end
        ADDR_TXDATA: begin
          if (!apb.pwrite || tx_full) err     = 1'b1;
          else                        tx_push = 1'b1;
        end
        ADDR_RXDATA: begin
          if (apb.pwrite || rx_empty) begin
            err = 1'b1;
          end else begin
            rdata  = 32'(rx_head);
            rx_pop = 1'b1;
          end
        end
        ADDR_LEVEL: begin
          if (apb.pwrite) err = 1'b1;
          else            rdata = {16'h0000, 8'(rx_count), 8'(tx_count)};
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pslverr = err;
  assign apb.pready  = access;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl        <= '0;
      slave_en    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl     <= ctrl_t'(apb.pwdata[CTRL_MODE_W-1:0]);
        slave_en <= apb.pwdata[CTRL_SS_LSB +: NUM_SS];
      end
      // A fresh overflow outranks a same-cycle W1C so no event is lost.
      if (flush)                   rx_overflow <= 1'b0;
      else if (rx_valid && rx_full) rx_overflow <= 1'b1;
      else if (ovf_clr)            rx_overflow <= 1'b0;
    end
  end

  assign tx_valid = ctrl.enable & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_head;

  assign ctrl_cpol     = ctrl.cpol;
  assign ctrl_cpha     = ctrl.cpha;
  assign ctrl_order    = ctrl.order;
  assign ctrl_rd       = ctrl.rd;
  assign ctrl_scks     = ctrl.scks;
  assign ctrl_slave_en = slave_en;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .wdata (apb.pwdata[DATA_W-1:0]),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (flush),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule

`default_nettype wire
